// File: rtl/sample_pkg.sv
// Shared constants for the sample datapath and its readout FIFO.
// Both sides size their buses from these values.
package sample_pkg;

    localparam int SAMPLE_DATA_W     = 16;
    localparam int SAMPLE_FIFO_DEPTH = 512;

endpackage

// File: rtl/sample_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is cleared by reset; array contents are kept.
module sample_fifo_ram
    import sample_pkg::*;
#(
    parameter int DATA_W = SAMPLE_DATA_W,
    parameter int DEPTH  = SAMPLE_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sample_sync_fifo.sv
// Single-clock sample FIFO with full/empty/prog_empty flags.
// Standard read latency: the word appears the cycle after rd_en.
module sample_sync_fifo
    import sample_pkg::*;
#(
    parameter int DATA_W            = SAMPLE_DATA_W,
    parameter int DEPTH             = SAMPLE_FIFO_DEPTH,
    parameter int PROG_EMPTY_THRESH = 4,
    localparam int AW               = $clog2(DEPTH),
    localparam int CW               = AW + 1
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              prog_empty,
    output logic [CW-1:0]     data_count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] PE_CNT   = CW'(PROG_EMPTY_THRESH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          full_q,   full_d;
    logic          empty_q,  empty_d;
    logic          pe_q,     pe_d;
    logic          wr_acc;
    logic          rd_acc;

    // Flags are registered, so acceptance is judged on the current flags:
    // a write at full is dropped even if a read frees a slot this edge.
    always_comb begin
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d = rd_ptr_q + AW'(rd_acc);
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
        full_d   = (count_d == FULL_CNT);
        empty_d  = (count_d == '0);
        pe_d     = (count_d <= PE_CNT);
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            pe_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            pe_q     <= pe_d;
        end
    end

    sample_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i     (core_clk),
        .rst_i     (core_rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (din),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (dout)
    );

    assign full       = full_q;
    assign empty      = empty_q;
    assign prog_empty = pe_q;
    assign data_count = count_q;

endmodule

// File: tb/tb_sample_sync_fifo.sv
// Scoreboard bench for sample_sync_fifo.
// A queue model tracks accepted words, count and the held read word.
module tb_sample_sync_fifo;
    import sample_pkg::*;

    localparam int DEPTH = SAMPLE_FIFO_DEPTH;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          core_clk = 1'b0;
    logic          core_rst = 1'b1;
    logic [15:0]   din      = '0;
    logic          wr_en    = 1'b0;
    logic          rd_en    = 1'b0;
    logic [15:0]   dout;
    logic          full;
    logic          empty;
    logic          prog_empty;
    logic [CW-1:0] data_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] sb[$];
    int          mcount   = 0;
    logic [15:0] mdout    = '0;

    sample_sync_fifo dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .prog_empty (prog_empty),
        .data_count (data_count)
    );

    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        mcount = 0;
        mdout  = '0;
    endtask

    // One clock of stimulus; returns the dout value the model expects.
    task automatic step(input logic we, input logic re,
                        input logic [15:0] d, output logic [15:0] expv);
        logic wok;
        logic rok;
        wok   = we && (mcount < DEPTH);
        rok   = re && (mcount > 0);
        wr_en = we;
        rd_en = re;
        din   = d;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (rok) mdout = sb.pop_front();
        if (wok) sb.push_back(d);
        mcount = mcount + int'(wok) - int'(rok);
        expv   = mdout;
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        wr_en    = 1'b1;
        rd_en    = 1'b1;
        din      = 16'hFFFF;
        tick();
        tick();
        core_rst = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        model_reset();
        n_checks++;
        if (dout !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_dout: got %h expected 0000", dout);
        end
        n_checks++;
        if ({empty, full, prog_empty} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_flags: got e%b f%b pe%b expected e1 f0 pe1",
                     empty, full, prog_empty);
        end
        n_checks++;
        if (data_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 0", data_count);
        end
    endtask

    task automatic test_basic();
        logic [15:0] e;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 16'(i), e);
            n_checks++;
            if (prog_empty !== (i <= 4)) begin
                n_fail++;
                $display("FAIL basic_pe_wr%0d: got %b expected %b",
                         i, prog_empty, (i <= 4));
            end
        end
        n_checks++;
        if (data_count !== CW'(5)) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected 5", data_count);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 16'h0, e);
            n_checks++;
            if (dout !== e || dout !== 16'(i)) begin
                n_fail++;
                $display("FAIL basic_rd%0d: got %h expected %h", i, dout, 16'(i));
            end
            n_checks++;
            if (prog_empty !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_pe_rd%0d: got %b expected 1", i, prog_empty);
            end
        end
        n_checks++;
        if (empty !== 1'b1 || data_count !== '0) begin
            n_fail++;
            $display("FAIL basic_empty: got e%b cnt %0d expected e1 cnt 0",
                     empty, data_count);
        end
    endtask

    task automatic test_fill();
        logic [15:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 16'(i) + 16'h2000, e);
        end
        n_checks++;
        if (full !== 1'b1 || empty !== 1'b0 || prog_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_flags: got f%b e%b pe%b expected f1 e0 pe0",
                     full, empty, prog_empty);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'hDEAD, e);
        end
        n_checks++;
        if (full !== 1'b1 || data_count !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL fill_over: got f%b cnt %0d expected f1 cnt %0d",
                     full, data_count, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 16'h0, e);
            n_checks++;
            if (dout !== e || dout !== 16'(i) + 16'h2000) begin
                n_fail++;
                $display("FAIL fill_drain%0d: got %h expected %h",
                         i, dout, 16'(i) + 16'h2000);
            end
        end
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || data_count !== '0) begin
            n_fail++;
            $display("FAIL fill_end: got e%b f%b cnt %0d expected e1 f0 cnt 0",
                     empty, full, data_count);
        end
    endtask

    task automatic test_empty_read();
        logic [15:0] e;
        step(1'b1, 1'b0, 16'h1234, e);
        step(1'b0, 1'b1, 16'h0, e);
        n_checks++;
        if (dout !== 16'h1234) begin
            n_fail++;
            $display("FAIL er_first: got %h expected 1234", dout);
        end
        step(1'b0, 1'b1, 16'h0, e);
        n_checks++;
        if (dout !== e || dout !== 16'h1234) begin
            n_fail++;
            $display("FAIL er_hold: got %h expected 1234", dout);
        end
        n_checks++;
        if (empty !== 1'b1 || data_count !== '0) begin
            n_fail++;
            $display("FAIL er_state: got e%b cnt %0d expected e1 cnt 0",
                     empty, data_count);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] e;
        step(1'b1, 1'b1, 16'hA000, e);
        n_checks++;
        if (dout !== e || dout !== 16'h1234 || data_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL sim_empty: got %h cnt %0d expected 1234 cnt 1",
                     dout, data_count);
        end
        step(1'b1, 1'b0, 16'hA001, e);
        step(1'b1, 1'b0, 16'hA002, e);
        step(1'b1, 1'b1, 16'hA003, e);
        n_checks++;
        if (dout !== e || dout !== 16'hA000 || data_count !== CW'(3)) begin
            n_fail++;
            $display("FAIL sim_mid: got %h cnt %0d expected a000 cnt 3",
                     dout, data_count);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b1, 16'h0, e);
            n_checks++;
            if (dout !== e || dout !== 16'hA000 + 16'(i)) begin
                n_fail++;
                $display("FAIL sim_drain%0d: got %h expected %h",
                         i, dout, 16'hA000 + 16'(i));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 16'hC000 + 16'(i), e);
        end
        step(1'b1, 1'b1, 16'hEEEE, e);
        n_checks++;
        if (dout !== e || dout !== 16'hC000) begin
            n_fail++;
            $display("FAIL sim_full_rd: got %h expected c000", dout);
        end
        n_checks++;
        if (full !== 1'b0 || data_count !== CW'(DEPTH - 1)) begin
            n_fail++;
            $display("FAIL sim_full_cnt: got f%b cnt %0d expected f0 cnt %0d",
                     full, data_count, DEPTH - 1);
        end
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 16'h0, e);
            n_checks++;
            if (dout !== e || dout !== 16'hC000 + 16'(i)) begin
                n_fail++;
                $display("FAIL sim_full_drain%0d: got %h expected %h",
                         i, dout, 16'hC000 + 16'(i));
            end
        end
        n_checks++;
        if (empty !== 1'b1 || data_count !== '0) begin
            n_fail++;
            $display("FAIL sim_end: got e%b cnt %0d expected e1 cnt 0",
                     empty, data_count);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        step(1'b1, 1'b0, 16'h0, e);
        for (int i = 1; i < 3 * DEPTH; i++) begin
            step(1'b1, 1'b1, 16'(i), e);
            n_checks++;
            if (dout !== e || dout !== 16'(i - 1)) begin
                n_fail++;
                $display("FAIL wrap%0d: got %h expected %h", i, dout, 16'(i - 1));
            end
        end
        step(1'b0, 1'b1, 16'h0, e);
        n_checks++;
        if (dout !== e || dout !== 16'(3 * DEPTH - 1) || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_last: got %h e%b expected %h e1",
                     dout, empty, 16'(3 * DEPTH - 1));
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] e;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 16'h7000 + 16'(i), e);
        end
        n_checks++;
        if (data_count !== CW'(10)) begin
            n_fail++;
            $display("FAIL mr_pre: got %0d expected 10", data_count);
        end
        core_rst = 1'b1;
        wr_en    = 1'b1;
        rd_en    = 1'b1;
        din      = 16'h5555;
        tick();
        core_rst = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        model_reset();
        n_checks++;
        if (data_count !== '0 || {empty, full, prog_empty} !== 3'b101) begin
            n_fail++;
            $display("FAIL mr_state: got cnt %0d e%b f%b pe%b expected 0 e1 f0 pe1",
                     data_count, empty, full, prog_empty);
        end
        n_checks++;
        if (dout !== 16'h0000) begin
            n_fail++;
            $display("FAIL mr_dout: got %h expected 0000", dout);
        end
        step(1'b1, 1'b0, 16'hBEEF, e);
        step(1'b0, 1'b1, 16'h0, e);
        n_checks++;
        if (dout !== e || dout !== 16'hBEEF || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_after: got %h e%b expected beef e1", dout, empty);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_empty_read();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
